mac_job_ctrl: RTL and testbench

//  Job sequencer and memory-port arbiter for the pipelined MAC unit. Accepts a start handshake, owns mac_compute,

---
 rtl/mac_pkg.sv | 26 ++
 rtl/mac_host_arb.sv | 18 +
 rtl/mac_job_ctrl.sv | 150 +++++++++++++++
 tb/tb_mac_job_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC job controller and the MAC unit.
// Holds the FSM state codes, status codes and the C write-back count for the default array size.
package mac_pkg;

  localparam int MAC_M       = 4;
  localparam int MAC_N       = 4;
  localparam int MAC_C_COUNT = MAC_M * MAC_N;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef enum logic [1:0] {
    ST_OK        = 2'b00,
    ST_TIMEOUT   = 2'b01,
    ST_COUNT_ERR = 2'b10,
    ST_ABORT     = 2'b11
  } status_e;

  // Number of C write-backs a complete M x N traversal produces.
  function automatic int c_count(input int m, input int n);
    return m * n;
  endfunction

endpackage

// File: rtl/mac_host_arb.sv
// Memory-port arbiter between the host and the MAC unit.
// The host may touch memory only while no job is active; a same-cycle start request beats host_req.
module mac_host_arb
  import mac_pkg::*;
(
  input  logic [1:0] state,
  input  logic       host_req,
  input  logic       start_valid,
  output logic       host_gnt,
  output logic       mem_sel_host
);

  always_comb begin
    host_gnt     = (state == S_IDLE) && host_req && !start_valid;
    mem_sel_host = (state == S_IDLE) || (state == S_DONE);
  end

endmodule

// File: rtl/mac_job_ctrl.sv
// Job sequencer for the pipelined MAC unit: start handshake, RUN/FLUSH timing, C write-back
// counting, timeout and abort handling, and a held status code / cycle count per job.
module mac_job_ctrl
  import mac_pkg::*;
#(
  parameter int param_M     = MAC_M,
  parameter int param_N     = MAC_N,
  parameter int TIMEOUT_CYC = 256,
  parameter int FLUSH_CYC   = 3,
  parameter int CYC_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             abort,
  input  logic             host_req,
  output logic             host_gnt,
  output logic             mem_sel_host,
  output logic             mac_compute,
  input  logic             mac_done,
  input  logic             mac_c_we,
  output logic             busy,
  output logic             done,
  output logic [1:0]       status,
  output logic [CYC_W-1:0] job_cycles
);

  localparam int C_EXP = c_count(param_M, param_N);
  localparam int CNT_W = $clog2(C_EXP + 1);
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam int FL_W  = $clog2(FLUSH_CYC + 1);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] C_EXP_V  = CNT_W'(C_EXP);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(FLUSH_CYC - 1);
  localparam logic [CYC_W-1:0] CYC_MAX  = '1;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] c_cnt_q, c_cnt_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [FL_W-1:0]  fl_q, fl_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  status_e          status_q, status_d;
  logic             mac_compute_q, mac_compute_d;

  logic [CNT_W-1:0] c_cnt_now;
  logic [CYC_W-1:0] cyc_inc;

  always_comb begin
    // Count including this cycle's strobe, so the final FLUSH cycle's write-back is judged too.
    c_cnt_now = c_cnt_q;
    if (mac_c_we && (c_cnt_q != CNT_MAX)) begin
      c_cnt_now = c_cnt_q + CNT_W'(1);
    end
    cyc_inc = (cyc_q == CYC_MAX) ? cyc_q : cyc_q + CYC_W'(1);

    state_d  = state_q;
    c_cnt_d  = c_cnt_q;
    tmr_d    = tmr_q;
    fl_d     = fl_q;
    cyc_d    = cyc_q;
    status_d = status_q;

    case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          state_d  = S_RUN;
          c_cnt_d  = '0;
          tmr_d    = '0;
          fl_d     = '0;
          cyc_d    = '0;
          status_d = ST_OK;
        end
      end
      S_RUN: begin
        c_cnt_d = c_cnt_now;
        cyc_d   = cyc_inc;
        tmr_d   = tmr_q + TMR_W'(1);
        // abort beats mac_done, which beats timeout
        if (abort) begin
          state_d  = S_DONE;
          status_d = ST_ABORT;
        end else if (mac_done) begin
          state_d = S_FLUSH;
        end else if (tmr_q == TMR_LAST) begin
          state_d  = S_DONE;
          status_d = ST_TIMEOUT;
        end
      end
      S_FLUSH: begin
        c_cnt_d = c_cnt_now;
        cyc_d   = cyc_inc;
        fl_d    = fl_q + FL_W'(1);
        if (abort) begin
          state_d  = S_DONE;
          status_d = ST_ABORT;
        end else if (fl_q == FL_LAST) begin
          state_d  = S_DONE;
          status_d = (c_cnt_now == C_EXP_V) ? ST_OK : ST_COUNT_ERR;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    mac_compute_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      c_cnt_q       <= '0;
      tmr_q         <= '0;
      fl_q          <= '0;
      cyc_q         <= '0;
      status_q      <= ST_OK;
      mac_compute_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      c_cnt_q       <= c_cnt_d;
      tmr_q         <= tmr_d;
      fl_q          <= fl_d;
      cyc_q         <= cyc_d;
      status_q      <= status_d;
      mac_compute_q <= mac_compute_d;
    end
  end

  mac_host_arb u_arb (
    .state        (state_q),
    .host_req     (host_req),
    .start_valid  (start_valid),
    .host_gnt     (host_gnt),
    .mem_sel_host (mem_sel_host)
  );

  assign start_ready = (state_q == S_IDLE);
  assign busy        = (state_q == S_RUN) || (state_q == S_FLUSH);
  assign done        = (state_q == S_DONE);
  assign mac_compute = mac_compute_q;
  assign status      = status_q;
  assign job_cycles  = cyc_q;

endmodule

// File: tb/tb_mac_job_ctrl.sv
// Scoreboard bench for mac_job_ctrl: each job is a per-cycle input trace, a trace-level model
// predicts status / cycle counts, and a negedge monitor checks every done pulse against the queue.
module tb_mac_job_ctrl;

  localparam int M   = 4;
  localparam int N   = 4;
  localparam int TO  = 32;
  localparam int FC  = 3;
  localparam int WIN = 40;

  logic        clk, rst;
  logic        start_valid, start_ready, abort, host_req, host_gnt, mem_sel_host;
  logic        mac_compute, mac_done, mac_c_we, busy, done;
  logic [1:0]  status;
  logic [15:0] job_cycles;

  mac_job_ctrl #(
    .param_M(M), .param_N(N), .TIMEOUT_CYC(TO), .FLUSH_CYC(FC), .CYC_W(16)
  ) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .abort(abort), .host_req(host_req), .host_gnt(host_gnt), .mem_sel_host(mem_sel_host),
    .mac_compute(mac_compute), .mac_done(mac_done), .mac_c_we(mac_c_we), .busy(busy),
    .done(done), .status(status), .job_cycles(job_cycles)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int st;
    int cyc;
    int mc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   we_a[WIN];
  bit   dn_a[WIN];
  bit   ab_a[WIN];

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Walk the input trace: RUN until abort / mac_done / timeout, then FLUSH_CYC cycles unless aborted.
  function automatic exp_t model();
    exp_t r;
    int   fs = -1;
    int   n  = 0;
    for (int t = 0; t < TO; t++) begin
      if (ab_a[t]) begin r.st = 3; r.cyc = t + 1; r.mc = t + 1; return r; end
      if (dn_a[t]) begin fs = t + 1; break; end
    end
    if (fs < 0) begin r.st = 1; r.cyc = TO; r.mc = TO; return r; end
    for (int t = fs; t < fs + FC; t++) begin
      if (ab_a[t]) begin r.st = 3; r.cyc = t + 1; r.mc = fs; return r; end
    end
    for (int t = 0; t < fs + FC; t++) n += int'(we_a[t]);
    r.st  = (n == M * N) ? 0 : 2;
    r.cyc = fs + FC;
    r.mc  = fs;
    return r;
  endfunction

  // Monitor: accumulate mac_compute / busy cycles and check each done pulse.
  initial begin
    int   mc_cnt = 0;
    int   busy_cnt = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        mc_cnt = 0;
        busy_cnt = 0;
      end else begin
        if (mac_compute) mc_cnt++;
        if (busy) busy_cnt++;
        if (done) begin
          if (exp_q.size() == 0) begin
            chk("done_without_job", int'(done), 0);
          end else begin
            e = exp_q.pop_front();
            chk("status", int'(status), e.st);
            chk("job_cycles", int'(job_cycles), e.cyc);
            chk("compute_cycles", mc_cnt, e.mc);
            chk("busy_cycles", busy_cnt, e.cyc);
            $display("job done: status=%0d job_cycles=%0d compute=%0d busy=%0d", status, job_cycles, mc_cnt, busy_cnt);
          end
          mc_cnt = 0;
          busy_cnt = 0;
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!start_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("idle_wait", int'(start_ready), 1);
  endtask

  // One job: k C strobes spread over [0,spread), optional mac_done / abort cycle (-1 = none).
  task automatic run_job(input int k, input int done_at, input int abort_at, input int spread);
    exp_t e;
    int   placed = 0;
    int   p;
    for (int t = 0; t < WIN; t++) begin we_a[t] = 0; dn_a[t] = 0; ab_a[t] = 0; end
    while (placed < k) begin
      p = $urandom_range(0, spread - 1);
      if (!we_a[p]) begin we_a[p] = 1; placed++; end
    end
    if (done_at >= 0 && done_at < WIN) dn_a[done_at] = 1;
    if (abort_at >= 0 && abort_at < WIN) ab_a[abort_at] = 1;
    e = model();
    // Strobes after the job has left RUN/FLUSH must be ignored by the DUT.
    for (int t = e.mc; t < WIN; t++) if ($urandom_range(0, 3) == 0) dn_a[t] = 1;
    for (int t = e.cyc; t < WIN; t++) begin
      we_a[t] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) ab_a[t] = 1;
    end

    wait_idle();
    exp_q.push_back(e);
    start_valid = 1'b1;
    host_req    = 1'($urandom_range(0, 1));
    #1;
    chk("gnt_on_start", int'(host_gnt), 0);
    chk("start_ready_idle", int'(start_ready), 1);
    @(posedge clk); #1;
    start_valid = 1'b0;
    for (int t = 0; t < WIN; t++) begin
      mac_c_we = we_a[t];
      mac_done = dn_a[t];
      abort    = ab_a[t];
      host_req = 1'($urandom_range(0, 1));
      #1;
      chk("host_gnt", int'(host_gnt), int'(t > e.cyc && host_req));
      chk("mem_sel_host", int'(mem_sel_host), int'(t >= e.cyc));
      chk("start_ready", int'(start_ready), int'(t > e.cyc));
      @(posedge clk); #1;
    end
    mac_c_we = 1'b0; mac_done = 1'b0; abort = 1'b0; host_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, da, aa, sp;
    rst = 1'b1; start_valid = 1'b0; abort = 1'b0; host_req = 1'b0;
    mac_done = 1'b0; mac_c_we = 1'b0;
    @(posedge clk); #2;
    chk("rst_start_ready", int'(start_ready), 1);
    chk("rst_host_gnt", int'(host_gnt), 0);
    chk("rst_mem_sel", int'(mem_sel_host), 1);
    chk("rst_mac_compute", int'(mac_compute), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_status", int'(status), 0);
    chk("rst_job_cycles", int'(job_cycles), 0);
    host_req = 1'b1; #1;
    chk("idle_gnt_req", int'(host_gnt), 1);
    start_valid = 1'b1; #1;
    chk("idle_gnt_conflict", int'(host_gnt), 0);
    start_valid = 1'b0; host_req = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    run_job(16, 16, -1, 16);  // nominal
    run_job(15, 16, -1, 16);  // one write-back short
    run_job(17, 16, -1, 20);  // one extra, partly during FLUSH
    run_job(16, -1, -1, 16);  // timeout
    run_job(16, 4, 4, 16);    // abort with mac_done on RUN cycle 5
    run_job(16, 16, 18, 16);  // abort during FLUSH
    run_job(16, TO - 1, -1, 34);  // mac_done on the timeout cycle
    for (int j = 0; j < 40; j++) begin
      k  = $urandom_range(14, 18);
      da = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(10, TO + 2));
      aa = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 36)) : -1;
      sp = $urandom_range(k, k + 6);
      run_job(k, da, aa, sp);
    end

    // Asynchronous reset in the middle of RUN.
    wait_idle();
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    for (int t = 0; t < 6; t++) begin
      mac_c_we = 1'b1;
      @(posedge clk); #1;
    end
    mac_c_we = 1'b0;
    host_req = 1'b1;
    chk("mc_before_rst", int'(mac_compute), 1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_mac_compute", int'(mac_compute), 0);
    chk("midrst_start_ready", int'(start_ready), 1);
    chk("midrst_status", int'(status), 0);
    chk("midrst_job_cycles", int'(job_cycles), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_host_gnt", int'(host_gnt), 1);
    @(posedge clk); #3 rst = 1'b0;
    host_req = 1'b0;
    @(posedge clk); #1;
    $display("reset mid-run: mac_compute=%0d start_ready=%0d status=%0d", mac_compute, start_ready, status);

    run_job(16, 20, -1, 20);  // recovery after reset
    @(posedge clk); #1;
    chk("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
